// File: rtl/vga_controller.sv
// 640x480 VGA timing from the 25 MHz clock; draws the score latched at the
// start of vertical blank as three 3x5-cell decimal digits centred on screen.
module vga_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] score,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  inout  logic        ps2_clk,
  inout  logic        ps2_data
);

  logic [9:0]  r_h;
  logic [9:0]  r_v;
  logic [3:0]  r_dig_h;
  logic [3:0]  r_dig_t;
  logic [3:0]  r_dig_u;
  logic        r_gameover;
  logic        r_hsync;
  logic        r_vsync;
  logic [11:0] r_rgb;

  logic [9:0]  w_sat;
  logic [3:0]  w_hund;
  logic [3:0]  w_tens;
  logic [3:0]  w_units;
  logic [6:0]  w_rem100;
  logic        w_latch;

  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic [1:0]  w_idx;
  logic [1:0]  w_col;
  logic [2:0]  w_row;
  logic [3:0]  w_digit;
  logic [14:0] w_mask;
  logic [2:0]  w_rowbits;
  logic        w_bit;
  logic        w_in_digit;
  logic        w_visible;
  logic [11:0] w_rgb;

  assign ps2_clk  = 1'bz;
  assign ps2_data = 1'bz;

  assign w_sat    = (score > 32'd999) ? 10'd999 : score[9:0];
  assign w_hund   = 4'(w_sat / 10'd100);
  assign w_rem100 = 7'(w_sat % 10'd100);
  assign w_tens   = 4'(w_rem100 / 7'd10);
  assign w_units  = 4'(w_rem100 % 7'd10);
  assign w_latch  = (r_h == 10'd0) && (r_v == 10'd480);

  // Rows top to bottom, three bits per row with the MSB as the left column.
  function automatic logic [14:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 15'b111_101_101_101_111;
      4'd1:    glyph = 15'b001_001_001_001_001;
      4'd2:    glyph = 15'b111_001_111_100_111;
      4'd3:    glyph = 15'b111_001_111_001_111;
      4'd4:    glyph = 15'b101_101_111_001_001;
      4'd5:    glyph = 15'b111_100_111_001_111;
      4'd6:    glyph = 15'b111_100_111_101_111;
      4'd7:    glyph = 15'b111_001_001_001_001;
      4'd8:    glyph = 15'b111_101_111_101_111;
      default: glyph = 15'b111_101_111_001_111;
    endcase
  endfunction

  assign w_dx = r_h - 10'd224;
  assign w_dy = r_v - 10'd200;

  // Digits sit on a 64-pixel pitch from x=224; offsets 48..63 are the gaps.
  always_comb begin
    w_idx      = w_dx[7:6];
    w_col      = w_dx[5:4];
    w_row      = w_dy[6:4];
    w_in_digit = (r_h >= 10'd224) && (w_dx < 10'd176) && (w_dx[5:4] != 2'd3) &&
                 (r_v >= 10'd200) && (w_dy < 10'd80);
    case (w_idx)
      2'd0:    w_digit = r_dig_h;
      2'd1:    w_digit = r_dig_t;
      default: w_digit = r_dig_u;
    endcase
    w_mask = glyph(w_digit);
    case (w_row)
      3'd0:    w_rowbits = w_mask[14:12];
      3'd1:    w_rowbits = w_mask[11:9];
      3'd2:    w_rowbits = w_mask[8:6];
      3'd3:    w_rowbits = w_mask[5:3];
      default: w_rowbits = w_mask[2:0];
    endcase
    case (w_col)
      2'd0:    w_bit = w_rowbits[2];
      2'd1:    w_bit = w_rowbits[1];
      default: w_bit = w_rowbits[0];
    endcase
    w_visible = (r_h < 10'd640) && (r_v < 10'd480);
    if (!w_visible)
      w_rgb = 12'h000;
    else if (w_in_digit && w_bit)
      w_rgb = r_gameover ? 12'h0F0 : 12'hFFF;
    else
      w_rgb = 12'h004;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h        <= '0;
      r_v        <= '0;
      r_dig_h    <= '0;
      r_dig_t    <= '0;
      r_dig_u    <= '0;
      r_gameover <= 1'b0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_rgb      <= '0;
    end else begin
      if (r_h == 10'd799) begin
        r_h <= '0;
        r_v <= (r_v == 10'd524) ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
      if (w_latch) begin
        r_dig_h    <= w_hund;
        r_dig_t    <= w_tens;
        r_dig_u    <= w_units;
        r_gameover <= (w_sat >= 10'd12);
      end
      r_hsync <= !((r_h >= 10'd656) && (r_h <= 10'd751));
      r_vsync <= !((r_v == 10'd490) || (r_v == 10'd491));
      r_rgb   <= w_rgb;
    end
  end

  assign hSync = r_hsync;
  assign vSync = r_vsync;
  assign VGA_R = r_rgb[11:8];
  assign VGA_G = r_rgb[7:4];
  assign VGA_B = r_rgb[3:0];

endmodule

// File: tb/tb_vga_controller.sv
// Directed bench for vga_controller: sync timing, digit pixels across score
// updates, game-over colour, saturation, mid-frame reset and idle PS/2 pins.
module tb_vga_controller;

  localparam int unsigned FRAME  = 800 * 525;
  localparam int unsigned RST_AT = 3 * FRAME + 260 * 800 + 300;
  localparam int unsigned END_B  = 248 * 800 + 384 + 11;

  typedef struct packed {
    logic [2:0]  f;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
  } pix_t;

  logic        clk;
  logic        reset;
  logic [31:0] score;
  logic        hSync;
  logic        vSync;
  logic [3:0]  VGA_R;
  logic [3:0]  VGA_G;
  logic [3:0]  VGA_B;
  wire         ps2_clk;
  wire         ps2_data;
  logic [11:0] rgb;

  pullup   (ps2_clk);
  pulldown (ps2_data);

  vga_controller dut (
    .clk      (clk),
    .reset    (reset),
    .score    (score),
    .hSync    (hSync),
    .vSync    (vSync),
    .VGA_R    (VGA_R),
    .VGA_G    (VGA_G),
    .VGA_B    (VGA_B),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  assign rgb = {VGA_R, VGA_G, VGA_B};

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int unsigned n_vec, n_err;
  int unsigned n, pf, pv, ph, idx;
  int unsigned hs_err, vs_err, blank_err, ps2_err, vs_low;
  int unsigned first_hfall, vfall0, vfall1;
  logic        prev_hs, prev_vs;
  bit          phase_b;
  pix_t        exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void add(input int unsigned f, input int unsigned x,
                              input int unsigned y, input logic [11:0] c);
    pix_t e;
    e.f   = 3'(f);
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.rgb = c;
    exp_q.push_back(e);
  endfunction

  // One clock; afterwards the outputs show pixel p = n-1 of the current run.
  task automatic tick();
    int unsigned p, r;
    @(posedge clk);
    #1;
    n++;
    p  = n - 1;
    pf = p / FRAME;
    r  = p % FRAME;
    pv = r / 800;
    ph = r % 800;
    if (hSync !== ((ph >= 656 && ph <= 751) ? 1'b0 : 1'b1)) hs_err++;
    if (vSync !== ((pv == 490 || pv == 491) ? 1'b0 : 1'b1)) vs_err++;
    if ((ph >= 640 || pv >= 480) && rgb !== 12'h000) blank_err++;
    if (ps2_clk !== 1'b1 || ps2_data !== 1'b0) ps2_err++;
    if (prev_hs === 1'b1 && hSync === 1'b0 && first_hfall == 0) first_hfall = n;
    if (!phase_b && prev_vs === 1'b1 && vSync === 1'b0) begin
      if (vfall0 == 0) vfall0 = n;
      else if (vfall1 == 0) vfall1 = n;
    end
    if (!phase_b && vSync === 1'b0 && p < 2 * FRAME) vs_low++;
    prev_hs = hSync;
    prev_vs = vSync;
    if (idx < exp_q.size() && int'(exp_q[idx].f) == int'(pf) &&
        int'(exp_q[idx].x) == int'(ph) && int'(exp_q[idx].y) == int'(pv)) begin
      chk($sformatf("pix f%0d (%0d,%0d)", pf, ph, pv), 32'(rgb), 32'(exp_q[idx].rgb));
      idx++;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; n = 0; idx = 0;
    hs_err = 0; vs_err = 0; blank_err = 0; ps2_err = 0; vs_low = 0;
    first_hfall = 0; vfall0 = 0; vfall1 = 0; phase_b = 1'b0;

    // frame 0: 000 white (score 0 -> 7 at v=100)
    add(0, 100, 100, 12'h004);
    add(0, 223, 200, 12'h004);
    add(0, 240, 200, 12'hFFF);
    add(0, 352, 216, 12'hFFF);
    add(0, 240, 220, 12'h004);
    // frame 1: 007 white (score -> 12)
    add(1, 352, 200, 12'hFFF);
    add(1, 352, 216, 12'h004);
    add(1, 384, 216, 12'hFFF);
    add(1, 224, 232, 12'hFFF);
    add(1, 399, 264, 12'hFFF);
    add(1, 400, 264, 12'h004);
    add(1, 224, 280, 12'h004);
    // frame 2: 012 green (score -> all ones)
    add(2, 240, 200, 12'h0F0);
    add(2, 320, 200, 12'h0F0);
    add(2, 288, 216, 12'h004);
    add(2, 352, 216, 12'h004);
    add(2, 384, 216, 12'h0F0);
    add(2, 352, 248, 12'h0F0);
    add(2, 384, 248, 12'h004);
    // frame 3: 999 green
    add(3, 240, 216, 12'h004);
    add(3, 240, 232, 12'h0F0);
    add(3, 352, 248, 12'h004);
    add(3, 384, 248, 12'h0F0);
    // after the mid-frame reset: 000 white
    add(0, 240, 200, 12'hFFF);
    add(0, 240, 232, 12'h004);
    add(0, 384, 248, 12'hFFF);

    reset = 1'b1;
    score = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hSync", 32'(hSync), 32'd1);
    chk("reset vSync", 32'(vSync), 32'd1);
    chk("reset rgb", 32'(rgb), 32'd0);
    chk("ps2_clk idle", 32'(ps2_clk), 32'd1);
    chk("ps2_data idle", 32'(ps2_data), 32'd0);
    reset   = 1'b0;
    prev_hs = hSync;
    prev_vs = vSync;

    while (n < RST_AT) begin
      tick();
      if (pv == 100 && ph == 0) begin
        if (pf == 0) score = 32'd7;
        else if (pf == 1) score = 32'd12;
        else if (pf == 2) score = 32'hFFFF_FFFF;
      end
    end
    chk("first hSync fall", first_hfall, 32'd657);
    chk("vSync fall 0", vfall0, 32'd392001);
    chk("vSync fall 1", vfall1, 32'd812001);
    chk("vSync low cycles", vs_low, 32'd3200);

    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset hSync", 32'(hSync), 32'd1);
    chk("midreset vSync", 32'(vSync), 32'd1);
    chk("midreset rgb", 32'(rgb), 32'd0);
    reset       = 1'b0;
    n           = 0;
    first_hfall = 0;
    phase_b     = 1'b1;
    prev_hs     = hSync;
    prev_vs     = vSync;

    while (n < END_B) tick();
    chk("post-reset hSync fall", first_hfall, 32'd657);
    chk("hSync window errors", hs_err, 32'd0);
    chk("vSync window errors", vs_err, 32'd0);
    chk("blank rgb errors", blank_err, 32'd0);
    chk("ps2 driven cycles", ps2_err, 32'd0);
    chk("pixels reached", idx, 32'(exp_q.size()));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
